// File: rtl/mem_wait_pkg.sv
// Shared types and defaults for the memory wait-state controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package mem_wait_pkg;

    typedef enum logic [1:0] {
        REG_RAM = 2'd0,
        REG_ROM = 2'd1,
        REG_IO  = 2'd2
    } region_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int unsigned WS_RAM_DEF  = 0;
    localparam int unsigned WS_ROM_DEF  = 1;
    localparam int unsigned WS_IO_DEF   = 3;
    localparam logic [7:0]  IO_PAGE_DEF = 8'hFD;
    localparam logic [7:0]  TIMEOUT_DEF = 8'd64;

    // Chip-select vector order is {io, rom, ram}.
    function automatic logic [2:0] region_onehot(input region_t r);
        case (r)
            REG_RAM: region_onehot = 3'b001;
            REG_ROM: region_onehot = 3'b010;
            REG_IO:  region_onehot = 3'b100;
            default: region_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Address-to-region decode: IO page first, then ROM window 20000-3FFFF, else RAM.
// Latency: combinational.
// Backpressure: none.
// Ports: address_next (20-bit physical address) -> region (region_t).
module mem_region_decode
    import mem_wait_pkg::*;
#(
    parameter logic [7:0] IO_PAGE = IO_PAGE_DEF
) (
    input  logic [19:0] address_next,
    output region_t     region
);

    always_comb begin
        region = REG_RAM;
        if (address_next[19:12] == IO_PAGE) begin
            region = REG_IO;
        end else if (address_next[19:17] == 3'b001) begin
            region = REG_ROM;
        end
    end

endmodule

// File: rtl/mem_wait_ctrl.sv
// Memory wait-state controller: per-region wait states, IO completion via ext_ack.
// Latency: ready drops for WS[region] cycles (IO: plus cycles until ext_ack).
// Backpressure: ready=0 stalls the core; address_next is ignored until ready returns.
// Ports: clk, reset (async active-low), address_next[19:0], ext_ack in;
//        ready, cs_ram, cs_rom, cs_io (registered one-hot), bus_err out.
// Build option: MEM_WAIT_TIMEOUT_EN enables the ext_ack timeout and bus_err pulse.
module mem_wait_ctrl
    import mem_wait_pkg::*;
#(
    parameter int unsigned WS_RAM  = WS_RAM_DEF,
    parameter int unsigned WS_ROM  = WS_ROM_DEF,
    parameter int unsigned WS_IO   = WS_IO_DEF,
    parameter logic [7:0]  IO_PAGE = IO_PAGE_DEF,
    parameter logic [7:0]  TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] address_next,
    input  logic        ext_ack,
    output logic        ready,
    output logic        cs_ram,
    output logic        cs_rom,
    output logic        cs_io,
    output logic        bus_err
);

    localparam logic [2:0] WS_RAM_C = 3'(WS_RAM);
    localparam logic [2:0] WS_ROM_C = 3'(WS_ROM);
    localparam logic [2:0] WS_IO_C  = 3'(WS_IO);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    region_t    region_dec, region_q;
    logic [2:0] ws_dec;
    logic [2:0] cs;

    mem_region_decode #(
        .IO_PAGE (IO_PAGE)
    ) u_decode (
        .address_next (address_next),
        .region       (region_dec)
    );

    always_comb begin
        ws_dec = WS_RAM_C;
        case (region_dec)
            REG_ROM: ws_dec = WS_ROM_C;
            REG_IO:  ws_dec = WS_IO_C;
            default: ws_dec = WS_RAM_C;
        endcase
    end

`ifdef MEM_WAIT_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       tout_hit;

    // The counter is held at zero outside ACK, so every ACK entry starts from 0.
    // Hitting TIMEOUT-1 on an edge means TIMEOUT full ACK cycles have elapsed.
    assign tout_hit = (tcnt == (TIMEOUT - 8'd1));
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (ws_dec != 3'd0) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = ws_dec;
                end else if (region_dec == REG_IO) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_nxt = (region_q == REG_IO) ? ST_ACK : ST_RUN;
                end
            end
            ST_ACK: begin
                if (ext_ack) begin
                    state_nxt = ST_RUN;
                end
`ifdef MEM_WAIT_TIMEOUT_EN
                else if (tout_hit) begin
                    state_nxt = ST_RUN;
                end
`endif
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_RUN;
            cnt      <= 3'd0;
            cs       <= 3'b000;
            region_q <= REG_RAM;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == ST_RUN) begin
                region_q <= region_dec;
                cs       <= region_onehot(region_dec);
            end
        end
    end

`ifdef MEM_WAIT_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt    <= 8'd0;
            bus_err <= 1'b0;
        end else begin
            tcnt    <= (state == ST_ACK) ? tcnt + 8'd1 : 8'd0;
            // ext_ack on the expiry edge completes normally, without an error.
            bus_err <= (state == ST_ACK) && !ext_ack && tout_hit;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

    assign ready  = (state == ST_RUN);
    assign cs_ram = cs[0];
    assign cs_rom = cs[1];
    assign cs_io  = cs[2];

endmodule
